psum_accum: RTL and testbench

Parametrised partial-sum accumulator for the NPU convolution datapath. It accepts one H-lane output column per beat from the PE array, and accumulates a full H×W output map across a programmable number of input channels. After the last channel it drains the accumulated map column by column, with optional saturation, over a valid/ready stream to the activation/pooling stage.

---
 rtl/psum_accum_pkg.sv | 36 +++
 rtl/psum_accum_if.sv | 32 +++
 rtl/psum_accum_sat_lane.sv | 15 +
 rtl/psum_accum.sv | 143 ++++++++++++++
 tb/tb_psum_accum.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_accum_pkg.sv
// Shared types and helpers for the partial-sum accumulator: FSM state encoding,
// channel-counter width derivation and the drain saturate/truncate function.
package npu_psum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_state_t;

  localparam int DEFAULT_MAX_CHAN = 16;

  function automatic int chan_w(input int max_chan);
    return $clog2(max_chan + 1);
  endfunction

  function automatic int col_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  // Works on a 64-bit signed carrier so one function serves every width pairing;
  // the caller keeps the low out_w bits of the result.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input logic sat_en,
                                                   input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (!sat_en)    return value;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/psum_accum_if.sv
// Input-beat and drained-column streams of the accumulator.
// Both streams: a beat transfers on a cycle where valid & ready are high at the clock edge;
// the producer keeps valid and data stable until that happens.
interface psum_accum_if
  import npu_psum_pkg::*;
#(
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 24
);
  localparam int COL_W = col_w(W);

  logic                    in_valid;
  logic                    in_ready;
  logic [H*DATA_WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [H*OUT_WIDTH-1:0]  out_data;
  logic [COL_W-1:0]        out_col;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_col
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_col
  );

endinterface

// File: rtl/psum_accum_sat_lane.sv
// One drain lane: signed ACC_WIDTH accumulator value to OUT_WIDTH, saturating or truncating.
module psum_sat_lane
  import npu_psum_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 24
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic                        sat_en_i,
  output logic        [OUT_WIDTH-1:0] out_o
);

  assign out_o = OUT_WIDTH'(sat_trunc(64'(acc_i), sat_en_i, OUT_WIDTH));

endmodule

// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums W columns of H lanes over num_chan channels,
// then drains the map column by column through per-lane saturation.
module psum_accum
  import npu_psum_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 24,
  parameter int H          = 12,
  parameter int W          = 11,
  parameter int MAX_CHAN   = DEFAULT_MAX_CHAN,
  parameter int CHAN_W     = chan_w(MAX_CHAN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CHAN_W-1:0] cfg_num_chan,
  input  logic              cfg_sat_en,
  psum_accum_if.slave       bus,
  output logic              busy,
  output logic              done,
  output psum_state_t       dbg_state_o
);

  localparam int COL_W = col_w(W);

  psum_state_t       state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [CHAN_W-1:0] num_chan_q, num_chan_d;
  logic              sat_en_q, sat_en_d;
  logic [CHAN_W-1:0] num_chan_clamped;

  logic [ACC_WIDTH-1:0] acc_q [H][W];
  logic [OUT_WIDTH-1:0] lane_out [H];
  logic [H*OUT_WIDTH-1:0] out_flat;

  wire last_col  = (col_q == COL_W'(W - 1));
  wire last_chan = (chan_q == num_chan_q - CHAN_W'(1));
  wire in_fire   = (state_q == ACCUM) && bus.in_valid;
  wire out_fire  = (state_q == DRAIN) && bus.out_ready;

  always_comb begin
    num_chan_clamped = cfg_num_chan;
    if (cfg_num_chan == '0)                          num_chan_clamped = CHAN_W'(1);
    else if (cfg_num_chan > CHAN_W'(MAX_CHAN))       num_chan_clamped = CHAN_W'(MAX_CHAN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      chan_q     <= '0;
      num_chan_q <= CHAN_W'(1);
      sat_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      chan_q     <= chan_d;
      num_chan_q <= num_chan_d;
      sat_en_q   <= sat_en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    chan_d     = chan_q;
    num_chan_d = num_chan_q;
    sat_en_d   = sat_en_q;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_chan_d = num_chan_clamped;
          sat_en_d   = cfg_sat_en;
          col_d      = '0;
          chan_d     = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          if (last_col) begin
            col_d = '0;
            if (last_chan) state_d = DRAIN;
            else           chan_d  = chan_q + CHAN_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (last_col) begin
            col_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel 0 overwrites the stored value, so the array never needs clearing.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int r = 0; r < H; r++) begin
        acc_q[r][col_q] <= (chan_q == '0 ? '0 : acc_q[r][col_q])
                           + ACC_WIDTH'($signed(bus.in_data[r*DATA_WIDTH +: DATA_WIDTH]));
      end
    end
  end

  for (genvar r = 0; r < H; r++) begin : g_lane
    psum_sat_lane #(
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_WIDTH(OUT_WIDTH)
    ) u_sat (
      .acc_i   (acc_q[r][col_q]),
      .sat_en_i(sat_en_q),
      .out_o   (lane_out[r])
    );
  end

  always_comb begin
    out_flat = '0;
    if (state_q == DRAIN) begin
      for (int r = 0; r < H; r++) out_flat[r*OUT_WIDTH +: OUT_WIDTH] = lane_out[r];
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = out_flat;
  assign bus.out_col   = (state_q == DRAIN) ? col_q : '0;
  assign busy          = (state_q != IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum with a 2x3 map, 8-bit lanes and a 12-bit accumulator.
module tb_psum_accum;
  import npu_psum_pkg::*;

  localparam int H  = 2;
  localparam int W  = 3;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int OW = 8;
  localparam int MC = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_num_chan = '0;
  logic          cfg_sat_en = 1'b0;
  logic          busy;
  logic          done;
  psum_state_t   dbg_state;

  psum_accum_if #(.H(H), .W(W), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  psum_accum #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
    .H(H), .W(W), .MAX_CHAN(MC), .CHAN_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_chan(cfg_num_chan), .cfg_sat_en(cfg_sat_en),
    .bus(bus), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [H*OW-1:0] got_data [W];
  logic [1:0]      got_col  [W];
  logic            got_done [W];
  logic            got_busy [W];
  int              hs;
  int              stall_bad;
  int              stray_done;
  logic            timeout;
  logic            busy_after;
  logic            valid_after;

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic start_job(input logic [CW-1:0] nc, input logic sat);
    start = 1'b1; cfg_num_chan = nc; cfg_sat_en = sat;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [DW-1:0] l0, input logic [DW-1:0] l1,
                      input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && (i % 2 == 1)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = {l1, l0};
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit bp);
    logic [3:0]      pat;
    logic [H*OW-1:0] held;
    logic            held_valid;
    int              k;
    pat = 4'b1001;
    hs = 0; k = 0; timeout = 1'b0; stall_bad = 0; stray_done = 0; held_valid = 1'b0; held = '0;
    while (hs < W) begin
      if (k >= 60) begin
        timeout = 1'b1;
        break;
      end
      bus.out_ready = bp ? pat[k % 4] : 1'b1;
      #1;
      if (held_valid && (bus.out_data !== held)) stall_bad++;
      if (bus.out_valid && bus.out_ready) begin
        got_data[hs] = bus.out_data;
        got_col[hs]  = bus.out_col;
        got_done[hs] = done;
        got_busy[hs] = busy;
        hs++;
        held_valid = 1'b0;
      end else begin
        if (done) stray_done++;
        held_valid = bus.out_valid;
        held       = bus.out_data;
      end
      k++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    #1;
    busy_after  = busy;
    valid_after = bus.out_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.out_col !== '0) begin failures++; $display("FAIL reset_out_col got=%0d exp=0", bus.out_col); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    start_job(5'd3, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL basic_start_ready got=%b%b exp=11", bus.in_ready, busy); end
    feed(8'd1, 8'd1, 9, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid_latency got=%b exp=1", bus.out_valid); end
    drain(1'b0);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout handshakes=%0d exp=%0d", hs, W); end
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'h0303) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=0303", i, got_data[i]); end
      checks++; if (got_col[i] !== 2'(i)) begin failures++; $display("FAIL basic_col[%0d] got=%0d exp=%0d", i, got_col[i], i); end
      checks++; if (got_done[i] !== (i == W - 1)) begin failures++; $display("FAIL basic_done[%0d] got=%b exp=%b", i, got_done[i], (i == W - 1)); end
    end
    checks++; if (got_busy[W-1] !== 1'b1 || busy_after !== 1'b0) begin failures++; $display("FAIL basic_busy_drop got=%b%b exp=10", got_busy[W-1], busy_after); end
    checks++; if (stray_done !== 0) begin failures++; $display("FAIL basic_stray_done got=%0d exp=0", stray_done); end
  endtask

  task automatic test_saturation;
    start_job(5'd4, 1'b1);
    feed(8'd100, 8'd100, 12, 1'b0);
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'h7F7F) begin failures++; $display("FAIL sat_on[%0d] got=%h exp=7f7f", i, got_data[i]); end
    end
    start_job(5'd4, 1'b0);
    feed(8'd100, 8'd100, 12, 1'b0);
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'h9090) begin failures++; $display("FAIL sat_off[%0d] got=%h exp=9090", i, got_data[i]); end
    end
  endtask

  task automatic test_sign_extend;
    start_job(5'd2, 1'b1);
    feed(8'h80, 8'd5, 6, 1'b0);
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'h0A80) begin failures++; $display("FAIL sign[%0d] got=%h exp=0a80", i, got_data[i]); end
    end
  endtask

  task automatic test_backpressure;
    start_job(5'd3, 1'b1);
    feed(8'd2, 8'hFD, 9, 1'b1);
    drain(1'b1);
    checks++; if (timeout !== 1'b0 || hs !== W) begin failures++; $display("FAIL bp_handshakes got=%0d exp=%0d", hs, W); end
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'hF706) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=f706", i, got_data[i]); end
      checks++; if (got_col[i] !== 2'(i)) begin failures++; $display("FAIL bp_col[%0d] got=%0d exp=%0d", i, got_col[i], i); end
    end
    checks++; if (stall_bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_bad); end
    checks++; if (valid_after !== 1'b0 || busy_after !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got=%b%b exp=00", valid_after, busy_after); end
    checks++; if (stray_done !== 0) begin failures++; $display("FAIL bp_stray_done got=%0d exp=0", stray_done); end
  endtask

  task automatic test_edge_config;
    start_job(5'd0, 1'b1);
    feed(8'd9, 8'hFF, 1, 1'b0);
    start = 1'b1; cfg_num_chan = 5'd5; cfg_sat_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    feed(8'd9, 8'hFF, 2, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL edge_zero_chan_drain got=%b exp=1", bus.out_valid); end
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'hFF09) begin failures++; $display("FAIL edge_zero_data[%0d] got=%h exp=ff09", i, got_data[i]); end
    end
    start_job(5'd31, 1'b1);
    feed(8'd1, 8'd1, 47, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL edge_clamp_early got=%b%b exp=01", bus.out_valid, busy); end
    feed(8'd1, 8'd1, 1, 1'b0);
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL edge_clamp_drain got=%b exp=1", bus.out_valid); end
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'h1010) begin failures++; $display("FAIL edge_clamp_data[%0d] got=%h exp=1010", i, got_data[i]); end
    end
  endtask

  task automatic test_reset_mid_job;
    start_job(5'd3, 1'b1);
    feed(8'd50, 8'd50, 4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_abort got=%b%b%b exp=000", busy, bus.in_ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
    start_job(5'd1, 1'b1);
    feed(8'd7, 8'd7, 3, 1'b0);
    drain(1'b0);
    for (int i = 0; i < W; i++) begin
      checks++; if (got_data[i] !== 16'h0707) begin failures++; $display("FAIL rst_mid_data[%0d] got=%h exp=0707", i, got_data[i]); end
    end
    checks++; if (got_done[W-1] !== 1'b1) begin failures++; $display("FAIL rst_mid_done got=%b exp=1", got_done[W-1]); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_sign_extend();
    test_backpressure();
    test_edge_config();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
